// File: rtl/segp2s_ctrl.sv
// Serialises DIGITS 7-segment bytes (active-low, digit DIGITS-1 first, MSB first) onto a
// seg_clk/seg_dt display shift chain. Define SEGP2S_AUTO_REFRESH_EN for periodic self-refresh.
module segp2s_ctrl #(
   parameter int DIGITS      = 8,
   parameter int CLK_DIV     = 4,
   parameter int REFRESH_GAP = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   hex,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   output logic                  busy,
   output logic                  done,
   output logic                  seg_clk,
   output logic                  seg_dt,
   output logic                  seg_en,
   output logic                  seg_clr,
   output logic [1:0]            dbg_state
);

   localparam int FW    = DIGITS * 8;
   localparam int BIT_W = (FW > 1) ? $clog2(FW) : 1;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FW - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   if (DIGITS < 1 || DIGITS > 16) begin : g_bad_digits
      $error("segp2s_ctrl: DIGITS must be 1..16");
   end
   if (CLK_DIV < 1) begin : g_bad_div
      $error("segp2s_ctrl: CLK_DIV must be >= 1");
   end
   if (REFRESH_GAP < 1) begin : g_bad_gap
      $error("segp2s_ctrl: REFRESH_GAP must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [FW-1:0]     sr_q, sr_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              hi_q, hi_d;
   logic              seg_clk_q, seg_clk_d;
   logic              seg_dt_q, seg_dt_d;
   logic              en_q;
   logic [FW-1:0]     frame;
   logic              go;
   logic              auto_go;

   // Byte layout {dp,g,f,e,d,c,b,a}, 0 = lit.
   function automatic logic [7:0] encode(input logic [3:0] h, input logic d, input logic b);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      if (b) encode = 8'hFF;
      else   encode = {~d, s};
   endfunction

   always_comb begin
      frame = '0;
      for (int i = 0; i < DIGITS; i++) begin
         frame[8*i +: 8] = encode(hex[4*i +: 4], dp[i], blank[i]);
      end
   end

`ifdef SEGP2S_AUTO_REFRESH_EN
   localparam int GAP_W = (REFRESH_GAP > 1) ? $clog2(REFRESH_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(REFRESH_GAP - 1);

   logic [GAP_W-1:0] gap_q, gap_d;

   // gap_q counts IDLE cycles already spent; the REFRESH_GAP-th one self-starts.
   assign auto_go = (state_q == IDLE) && (gap_q == GAP_LAST);

   always_comb begin
      gap_d = '0;
      if (state_q == IDLE && !go) gap_d = gap_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) gap_q <= '0;
      else     gap_q <= gap_d;
   end
`else
   assign auto_go = 1'b0;
`endif

   assign go = (state_q == IDLE) && (start || auto_go);

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      bit_d     = bit_q;
      div_d     = div_q;
      hi_d      = hi_q;
      seg_clk_d = seg_clk_q;
      seg_dt_d  = seg_dt_q;
      case (state_q)
         IDLE: begin
            if (go) begin
               sr_d      = frame << 1;
               seg_dt_d  = frame[FW-1];
               seg_clk_d = 1'b0;
               bit_d     = '0;
               div_d     = '0;
               hi_d      = 1'b0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (!hi_q) begin
                  hi_d      = 1'b1;
                  seg_clk_d = 1'b1;
               end else if (bit_q == BIT_LAST) begin
                  hi_d    = 1'b0;
                  bit_d   = '0;
                  state_d = DONE;
               end else begin
                  // New bit goes out on the falling edge so it is stable for the next rise.
                  hi_d      = 1'b0;
                  seg_clk_d = 1'b0;
                  bit_d     = bit_q + 1'b1;
                  seg_dt_d  = sr_q[FW-1];
                  sr_d      = sr_q << 1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sr_q      <= '0;
         bit_q     <= '0;
         div_q     <= '0;
         hi_q      <= 1'b0;
         seg_clk_q <= 1'b1;
         seg_dt_q  <= 1'b0;
         en_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         bit_q     <= bit_d;
         div_q     <= div_d;
         hi_q      <= hi_d;
         seg_clk_q <= seg_clk_d;
         seg_dt_q  <= seg_dt_d;
         en_q      <= 1'b1;
      end
   end

   assign busy      = (state_q == SHIFT);
   assign done      = (state_q == DONE);
   assign seg_clk   = seg_clk_q;
   assign seg_dt    = seg_dt_q;
   assign seg_en    = en_q;
   assign seg_clr   = en_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_segp2s_ctrl.sv
// Directed bench for segp2s_ctrl: instance A (DIGITS=8, CLK_DIV=2) and instance B
// (DIGITS=1, CLK_DIV=1); expected bytes and cycle positions are hand-computed constants.
module tb_segp2s_ctrl;

`ifdef SEGP2S_AUTO_REFRESH_EN
   localparam int GAP_A = 16;
`else
   localparam int GAP_A = 1024;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start_a, start_b;
   logic [31:0] hex_a;
   logic [7:0]  dp_a, blank_a;
   logic [3:0]  hex_b;
   logic        dp_b, blank_b;
   logic        busy_a, done_a, seg_clk_a, seg_dt_a, seg_en_a, seg_clr_a;
   logic        busy_b, done_b, seg_clk_b, seg_dt_b, seg_en_b, seg_clr_b;
   logic [1:0]  dbg_a, dbg_b;

   segp2s_ctrl #(.DIGITS(8), .CLK_DIV(2), .REFRESH_GAP(GAP_A)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .hex(hex_a), .dp(dp_a), .blank(blank_a),
      .busy(busy_a), .done(done_a), .seg_clk(seg_clk_a), .seg_dt(seg_dt_a),
      .seg_en(seg_en_a), .seg_clr(seg_clr_a), .dbg_state(dbg_a)
   );

   segp2s_ctrl #(.DIGITS(1), .CLK_DIV(1)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .hex(hex_b), .dp(dp_b), .blank(blank_b),
      .busy(busy_b), .done(done_b), .seg_clk(seg_clk_b), .seg_dt(seg_dt_b),
      .seg_en(seg_en_b), .seg_clr(seg_clr_b), .dbg_state(dbg_b)
   );

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic bits_a[$];
   logic bits_b[$];
   logic prev_a = 1'b1;
   logic prev_b = 1'b1;

   // Capture seg_dt at each seg_clk rise while a frame is in flight.
   always @(negedge clk) begin
      if (busy_a && seg_clk_a && !prev_a) bits_a.push_back(seg_dt_a);
      if (busy_b && seg_clk_b && !prev_b) bits_b.push_back(seg_dt_b);
      prev_a = seg_clk_a;
      prev_b = seg_clk_b;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check_bytes(input string tag, input bit use_b);
      int n;
      int i;
      logic [7:0] byte_v;
      logic [7:0] exp_v;
      n = use_b ? bits_b.size() : bits_a.size();
      check({tag, "_nbits"}, n, exp_q.size() * 8);
      i = 0;
      while (exp_q.size() > 0) begin
         exp_v  = exp_q.pop_front();
         byte_v = 8'h00;
         for (int j = 0; j < 8; j++) begin
            if (i*8 + j < n) byte_v = {byte_v[6:0], (use_b ? bits_b[i*8+j] : bits_a[i*8+j])};
         end
         check($sformatf("%s_byte%0d", tag, i), byte_v, exp_v);
         i++;
      end
   endtask

`ifndef SEGP2S_AUTO_REFRESH_EN
   // Called at the negedge of cycle t; returns at the negedge of cycle t+257.
   task automatic do_frame(input string tag, input logic [31:0] h, input logic [7:0] d,
                           input logic [7:0] b, input bit chain);
      int dn;
      dn = 0;
      check({tag, "_idle_busy"}, busy_a, 1'b0);
      check({tag, "_idle_done"}, done_a, 1'b0);
      hex_a = h; dp_a = d; blank_a = b; start_a = 1'b1;
      bits_a.delete();
      for (int k = 1; k <= 257; k++) begin
         step();
         if (k == 1) begin
            check({tag, "_busy_t1"}, busy_a, 1'b1);
            check({tag, "_clk_t1"}, seg_clk_a, 1'b0);
            check({tag, "_dbg_t1"}, dbg_a, 2'd1);
         end
         if (k == 3) check({tag, "_clk_t3"}, seg_clk_a, 1'b1);
         if (k == 5) check({tag, "_clk_t5"}, seg_clk_a, 1'b0);
         if (k == 256) check({tag, "_busy_t256"}, busy_a, 1'b1);
         if (k < 257 && done_a) dn++;
         if (k == 257) begin
            check({tag, "_done_t257"}, done_a, 1'b1);
            check({tag, "_busy_t257"}, busy_a, 1'b0);
            check({tag, "_clk_t257"}, seg_clk_a, 1'b1);
         end
         start_a = (k == 50) || (chain && k == 257);
         if (k == 1) begin
            hex_a = ~h; dp_a = ~d; blank_a = ~b;
         end
      end
      check({tag, "_early_done"}, dn, 0);
      check_bytes(tag, 1'b0);
   endtask
`endif

   initial begin
      int dn;
      int busy_cnt;
      int done_t[$];
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
      hex_a = '0; dp_a = '0; blank_a = '0;
      hex_b = '0; dp_b = 1'b0; blank_b = 1'b0;
      step(); step();
      start_a = 1'b1; start_b = 1'b1;
      step();
      start_a = 1'b0; start_b = 1'b0;
      check("rst_busy", busy_a, 1'b0);
      check("rst_done", done_a, 1'b0);
      check("rst_clk", seg_clk_a, 1'b1);
      check("rst_dt", seg_dt_a, 1'b0);
      check("rst_en", seg_en_a, 1'b0);
      check("rst_clr", seg_clr_a, 1'b0);
      check("rst_dbg", dbg_a, 2'd0);
      check("rst_busy_b", busy_b, 1'b0);
      rst = 1'b0;
      step();
      check("post_rst_en", seg_en_a, 1'b1);
      check("post_rst_clr", seg_clr_a, 1'b1);
      check("post_rst_busy", busy_a, 1'b0);

`ifdef SEGP2S_AUTO_REFRESH_EN
      hex_a = 32'h0123_4567; start_a = 1'b1;
      for (int k = 1; k <= 820; k++) begin
         step();
         start_a = 1'b0;
         if (done_a) done_t.push_back(k);
      end
      check("auto_ndone", done_t.size(), 3);
      while (done_t.size() < 3) done_t.push_back(0);
      check("auto_done0", done_t[0], 257);
      check("auto_done1", done_t[1], 530);
      check("auto_done2", done_t[2], 803);
`else
      exp_q = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
      do_frame("f1", 32'h0123_4567, 8'h00, 8'h00, 1'b1);
      step();
      exp_q = '{8'h40, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hFF};
      do_frame("f2", 32'h0123_4567, 8'h80, 8'h01, 1'b0);
      step();

      hex_a = 32'h0123_4567; dp_a = 8'h00; blank_a = 8'h00; start_a = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         step();
         start_a = 1'b0;
         if (k == 100) begin
            check("abort_pre_busy", busy_a, 1'b1);
            check("abort_pre_dt", seg_dt_a, 1'b1);
            rst = 1'b1;
         end
      end
      step();
      rst = 1'b0;
      check("abort_busy", busy_a, 1'b0);
      check("abort_done", done_a, 1'b0);
      check("abort_clk", seg_clk_a, 1'b1);
      check("abort_dt", seg_dt_a, 1'b0);
      check("abort_clr", seg_clr_a, 1'b0);
      check("abort_en", seg_en_a, 1'b0);
      dn = 0;
      for (int k = 0; k < 300; k++) begin
         step();
         if (done_a) dn++;
      end
      check("abort_no_done", dn, 0);
      check("abort_idle", busy_a, 1'b0);
`endif

      hex_b = 4'hF; dp_b = 1'b0; blank_b = 1'b0; start_b = 1'b1;
      bits_b.delete();
      dn = 0; busy_cnt = 0;
      for (int k = 1; k <= 17; k++) begin
         step();
         start_b = 1'b0;
         if (busy_b) busy_cnt++;
         if (k < 17 && done_b) dn++;
         if (k == 17) begin
            check("b_done_t17", done_b, 1'b1);
            check("b_busy_t17", busy_b, 1'b0);
         end
      end
      check("b_busy_cycles", busy_cnt, 16);
      check("b_early_done", dn, 0);
      exp_q = '{8'h8E};
      check_bytes("b", 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/segp2s_ctrl.md
SEGP2S_CTRL -- requirements
Module: segp2s_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of 7-segment digits in the serial chain (1..16).
REQ-002 SHALL have parameter CLK_DIV, default 4, clk cycles per seg_clk half-period (>=1).
REQ-003 SHALL have parameter REFRESH_GAP, default 1024, idle clk cycles between automatic refreshes (used only under REQ-024).
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to capture the inputs and shift one frame.
REQ-007 hex  input  4*DIGITS  hex value per digit; digit i = hex[4i+3:4i].
REQ-008 dp  input  DIGITS  decimal point per digit, 1 = lit.
REQ-009 blank  input  DIGITS  1 = digit i fully dark.
REQ-010 busy  output  1  high while a frame is shifting.
REQ-011 done  output  1  one-cycle pulse after the last bit.
REQ-012 seg_clk  output  1  serial clock to the display shift chain; idles high.
REQ-013 seg_dt  output  1  serial data, valid at seg_clk rising edge.
REQ-014 seg_en  output  1  display enable, active-high.
REQ-015 seg_clr  output  1  display chain clear, active-low.

Function
REQ-016 Each digit SHALL encode to byte {dp,g,f,e,d,c,b,a}, active-low (0 = lit); hex digits 0-F use the standard 7-segment glyphs (A,b,C,d,E,F for 10-15); blank[i]=1 forces 8'hFF regardless of hex and dp.
REQ-017 FSM SHALL have states IDLE, SHIFT, DONE; reset enters IDLE.
REQ-018 IDLE: start=1 in cycle t latches all DIGITS bytes into a DIGITS*8-bit shift register; SHIFT begins at t+1; busy=1 from t+1.
REQ-019 SHIFT: bits SHALL leave in order digit DIGITS-1 first, bit 7 first, ending with digit 0 bit 0; each bit occupies 2*CLK_DIV cycles: seg_dt updated as seg_clk falls, seg_clk low CLK_DIV cycles then high CLK_DIV cycles.
REQ-020 After DIGITS*8 bits (DIGITS*16*CLK_DIV cycles) FSM SHALL enter DONE for exactly one cycle: done=1, busy=0, seg_clk=1; then IDLE.
REQ-021 start SHALL be ignored in SHIFT and DONE (no queuing); inputs changing during SHIFT SHALL not affect the frame in flight.
REQ-022 Outside SHIFT, seg_clk SHALL be 1 and seg_dt SHALL hold its last value; seg_en=1 and seg_clr=1 whenever rst=0.
REQ-023 Bit and divider counters SHALL be sized by $clog2 of their terminal counts; no wrap-around beyond terminal count.

Configuration
REQ-024 Macro SEGP2S_AUTO_REFRESH_EN defined: after REFRESH_GAP consecutive IDLE cycles the block SHALL self-start exactly as a start pulse on that cycle; an external start in IDLE starts immediately and resets the gap count. Not defined: frames start only on start; REFRESH_GAP unused; no gap counter synthesised.

Reset
REQ-025 rst=1 at any cycle, including mid-SHIFT, SHALL on the next edge force IDLE, busy=0, done=0, seg_clk=1, seg_dt=0, seg_en=0, seg_clr=0, shift register and counters 0; no done pulse for an aborted frame.
REQ-026 start asserted together with rst SHALL be ignored.

Verification (DIGITS=8, CLK_DIV=2, unless stated)
REQ-027 hex=32'h0123_4567, dp=0, blank=0, start at t -> busy t+1..t+256, done at t+257; sampled bytes at seg_clk rises: C0 F9 A4 B0 99 92 82 F8.
REQ-028 Same hex, dp=8'h80, blank=8'h01 -> first byte 40, last byte FF, others as REQ-027.
REQ-029 start pulsed at t, again at t+50 and t+257 -> single done at t+257, no second frame; start at t+258 accepted.
REQ-030 rst asserted at t+100 mid-frame -> t+101: busy=0, seg_clk=1, seg_dt=0, seg_clr=0; no done pulse afterwards.
REQ-031 SEGP2S_AUTO_REFRESH_EN, REFRESH_GAP=16, single start at t -> done at t+257, t+530, t+803 (period 273) with no further start.
REQ-032 DIGITS=1, CLK_DIV=1, hex=4'hF -> busy 16 cycles, byte 8E, done at t+17.
